// File: rtl/wd_pkg.sv
// -----------------------------------------------------------------------------
// wd_pkg
// Definitions shared by the watchdog register block and the watchdog timing
// core: mode encodings, FSM state encoding, register addresses and the
// default counter width.
// -----------------------------------------------------------------------------
package wd_pkg;

    // Default width of the down-counter and of StartValue.
    localparam int CNT_W_DEF = 32;

    // Watchdog mode encodings, as written to the mode register.
    localparam logic [1:0] WD_MODE_OFF    = 2'b00;
    localparam logic [1:0] WD_MODE_IRQ    = 2'b01;
    localparam logic [1:0] WD_MODE_RST    = 2'b10;
    localparam logic [1:0] WD_MODE_IRQRST = 2'b11;

    // Timing core FSM states; the encoding is exported on wd_state.
    typedef enum logic [1:0] {
        WD_DISABLED = 2'd0,
        WD_COUNT    = 2'd1,
        WD_WARN     = 2'd2,
        WD_RESET    = 2'd3
    } wd_state_e;

    // Register block address map (byte offsets).
    localparam logic [7:0] reg_StartValue = 8'h00;
    localparam logic [7:0] reg_feeddog    = 8'h04;
    localparam logic [7:0] reg_mode       = 8'h08;

    // True when the mode field enables the watchdog.
    function automatic logic wd_mode_enabled(input logic [1:0] mode_v);
        return (mode_v != WD_MODE_OFF);
    endfunction

endpackage

// File: rtl/wd_rst_pulse.sv
// -----------------------------------------------------------------------------
// wd_rst_pulse
// Stretches a one-cycle start request into a registered pulse exactly
// RST_CYCLES clock cycles long. The pulse rises on the same edge that samples
// i_start and cannot be retriggered or cut short except by prst.
//
// Ports:
//   pclk     in   clock, rising edge
//   prst     in   synchronous reset, active-high
//   i_start  in   one-cycle start request
//   o_pulse  out  stretched pulse (registered)
//   o_busy   out  pulse in progress
//   o_last   out  current cycle is the final cycle of the pulse
// -----------------------------------------------------------------------------
module wd_rst_pulse #(
    parameter int RST_CYCLES = 16
) (
    input  logic pclk,
    input  logic prst,
    input  logic i_start,
    output logic o_pulse,
    output logic o_busy,
    output logic o_last
);

    // Counter holds the number of pulse cycles still to come after this one.
    localparam int PW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [PW-1:0] LOAD_VAL = PW'(RST_CYCLES - 1);

    logic          r_pulse;
    logic [PW-1:0] r_left;

    // Pulse register and remaining-cycle counter.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_pulse <= 1'b0;
            r_left  <= '0;
        end else if (r_pulse) begin
            if (r_left == '0) begin
                r_pulse <= 1'b0;
            end else begin
                r_left <= r_left - PW'(1);
            end
        end else if (i_start) begin
            r_pulse <= 1'b1;
            r_left  <= LOAD_VAL;
        end else begin
            r_pulse <= r_pulse;
            r_left  <= r_left;
        end
    end

    assign o_pulse = r_pulse;
    assign o_busy  = r_pulse;
    assign o_last  = r_pulse & (r_left == '0);

endmodule

// File: rtl/wd_counter.sv
// -----------------------------------------------------------------------------
// wd_counter
// Watchdog timing core. Runs a down-counter reloaded from StartValue by feed
// (flag) or StartValue update pulses. On expiry it raises a sticky interrupt
// and/or a stretched watchdog reset request, depending on mode.
//
// Ports:
//   pclk        in   clock, rising edge
//   prst        in   synchronous reset, active-high
//   flag        in   feed-dog pulse
//   mode        in   00 off, 01 irq, 10 reset, 11 irq-then-reset
//   update      in   StartValue-written pulse
//   StartValue  in   reload value
//   count       out  current counter value
//   wd_irq      out  sticky level interrupt
//   wd_rst      out  watchdog reset request, RST_CYCLES long
//   wd_state    out  FSM state
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module wd_counter
    import wd_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int RST_CYCLES = 16
) (
    input  logic             pclk,
    input  logic             prst,
    input  logic             flag,
    input  logic [1:0]       mode,
    input  logic             update,
    input  logic [CNT_W-1:0] StartValue,
    output logic [CNT_W-1:0] count,
    output logic             wd_irq,
    output logic             wd_rst,
    output logic [1:0]       wd_state
);

    wd_state_e        r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_irq;

    wd_state_e        w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_irq_nxt;
    logic             w_pulse_start;
    logic             w_pulse;
    logic             w_pulse_busy;
    logic             w_pulse_last;

    wd_rst_pulse #(
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_pulse (
        .pclk    (pclk),
        .prst    (prst),
        .i_start (w_pulse_start),
        .o_pulse (w_pulse),
        .o_busy  (w_pulse_busy),
        .o_last  (w_pulse_last)
    );

    // State, counter and interrupt registers.
    always_ff @(posedge pclk) begin
        if (prst) begin
            r_state <= WD_COUNT;
            r_count <= {CNT_W{1'b1}};
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_irq   <= w_irq_nxt;
        end
    end

    // Next-state, counter and interrupt logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_irq_nxt     = r_irq;
        w_pulse_start = 1'b0;

        case (r_state)
            WD_DISABLED: begin
                // StartValue is only sampled at the moment of enabling.
                w_irq_nxt = 1'b0;
                if (wd_mode_enabled(mode)) begin
                    w_count_nxt = StartValue;
                    w_state_nxt = WD_COUNT;
                end else begin
                    w_state_nxt = WD_DISABLED;
                end
            end

            WD_COUNT, WD_WARN: begin
                if (!wd_mode_enabled(mode)) begin
                    w_state_nxt = WD_DISABLED;
                    w_irq_nxt   = 1'b0;
                end else if (flag || update) begin
                    w_count_nxt = StartValue;
                    w_state_nxt = WD_COUNT;
                    w_irq_nxt   = 1'b0;
                end else if (r_count == '0) begin
                    // Timeout: always reload; action depends on mode and state.
                    w_count_nxt = StartValue;
                    case (mode)
                        WD_MODE_IRQ: begin
                            w_irq_nxt   = 1'b1;
                            w_state_nxt = WD_COUNT;
                        end
                        WD_MODE_RST: begin
                            w_state_nxt   = WD_RESET;
                            w_pulse_start = 1'b1;
                        end
                        WD_MODE_IRQRST: begin
                            if (r_state == WD_COUNT) begin
                                w_irq_nxt   = 1'b1;
                                w_state_nxt = WD_WARN;
                            end else begin
                                w_state_nxt   = WD_RESET;
                                w_pulse_start = 1'b1;
                            end
                        end
                        default: begin
                            w_state_nxt = r_state;
                        end
                    endcase
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end

            WD_RESET: begin
                // Inputs are ignored until the pulse finishes; a pulse that is
                // somehow not running also releases the state.
                if (w_pulse_last || !w_pulse_busy) begin
                    w_irq_nxt   = 1'b0;
                    w_count_nxt = StartValue;
                    if (wd_mode_enabled(mode)) begin
                        w_state_nxt = WD_COUNT;
                    end else begin
                        w_state_nxt = WD_DISABLED;
                    end
                end else begin
                    w_state_nxt = WD_RESET;
                end
            end

            default: begin
                w_state_nxt = WD_COUNT;
            end
        endcase
    end

    assign count    = r_count;
    assign wd_irq   = r_irq;
    assign wd_rst   = w_pulse;
    assign wd_state = r_state;

endmodule
